// File: rtl/stack_alu.sv
// Binary-op execution stage behind the operand stack: single-cycle logic ops, iterative MUL,
// and an optional restoring divider enabled by defining STACK_ALU_DIV_EN.
module stack_alu #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] tos,
    input  logic [WIDTH-1:0] nos,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             pop_alu,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(WIDTH - 1);

    logic [1:0]          state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                pop_q, pop_d;
    logic                err_q, err_d;
`ifdef STACK_ALU_DIV_EN
    logic                div_q, div_d;
    logic [WIDTH:0]      rem_shift;
    logic [WIDTH:0]      rem_diff;
`endif

    function automatic logic [WIDTH-1:0] simple_op(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            3'b000:  simple_op = a + b;
            3'b001:  simple_op = a - b;
            3'b010:  simple_op = a & b;
            3'b011:  simple_op = a | b;
            3'b100:  simple_op = a ^ b;
            3'b101:  simple_op = (sa < sb) ? WIDTH'(1) : '0;
            default: simple_op = '0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        pop_d    = 1'b0;
        err_d    = 1'b0;
`ifdef STACK_ALU_DIV_EN
        div_d     = div_q;
        rem_shift = '0;
        rem_diff  = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = nos;
                    b_d   = tos;
                    acc_d = '0;
                    cnt_d = '0;
                    if (opcode <= 3'b101) begin
                        result_d = simple_op(opcode, nos, tos);
                        pop_d    = 1'b1;
                        state_d  = S_DONE;
                    end else if (opcode == 3'b110) begin
`ifdef STACK_ALU_DIV_EN
                        div_d   = 1'b0;
`endif
                        state_d = S_ITER;
                    end else begin
`ifdef STACK_ALU_DIV_EN
                        if (tos == '0) begin
                            result_d = '1;
                            err_d    = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            div_d   = 1'b1;
                            state_d = S_ITER;
                        end
`else
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
`endif
                    end
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + CNT_BITS'(1);
`ifdef STACK_ALU_DIV_EN
                if (div_q) begin
                    // a_q doubles as dividend shifter and quotient collector
                    rem_shift = {acc_q, a_q[WIDTH-1]};
                    rem_diff  = rem_shift - {1'b0, b_q};
                    if (!rem_diff[WIDTH]) begin
                        acc_d = rem_diff[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_shift[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    if (b_q[0]) acc_d = acc_q + a_q;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end
                if (cnt_q == LAST_ITER) begin
`ifdef STACK_ALU_DIV_EN
                    result_d = div_q ? a_d : acc_d;
`else
                    result_d = acc_d;
`endif
                    pop_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            pop_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef STACK_ALU_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            pop_q    <= pop_d;
            err_q    <= err_d;
`ifdef STACK_ALU_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign result  = result_q;
    assign pop_alu = pop_q;
    assign err     = err_q;

endmodule
